mux_4_3: RTL and testbench
==========================

MUX_4_3 -- requirements
Module: mux_4_3

Interface
REQ-001 Parameter W: default 5; data width of every data input and output.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in0  input  W  data source selected by sel=0.
REQ-005 in1  input  W  data source selected by sel=1.
REQ-006 in2  input  W  data source selected by sel=2.
REQ-007 sel  input  2  source select; the legal codes are 0..2 and code 3 is illegal.
REQ-008 out  output  W  combinational selected data.
REQ-009 out_q  output  W  registered copy of out.
REQ-010 sel_err  output  1  combinational flag, high while sel=3.
REQ-011 err_sticky  output  1  registered flag; latches high after any clock edge that sampled sel=3.
REQ-012 Port order for positional instantiation SHALL be: clk, reset, in0, in1, in2, sel, out, out_q, sel_err, err_sticky.

Function
REQ-013 out SHALL equal in0, in1 or in2 when sel is 0, 1 or 2 respectively, with zero cycles of latency.
REQ-014 When sel=3, out SHALL be all-zero and sel_err SHALL be 1; no latch inference is allowed.
REQ-015 sel_err SHALL be 0 for sel 0..2.
REQ-016 out SHALL respond to a change on any of in0, in1, in2 or sel in the same delta cycle.
REQ-017 out_q SHALL load the value of out on every rising clk edge where reset=0, giving one cycle of latency.
REQ-018 err_sticky SHALL go to 1 on the first rising edge where reset=0 and sel=3.
REQ-019 err_sticky SHALL then hold 1 until reset, regardless of later sel values.
REQ-020 Data SHALL be passed bit-exact with no sign extension, truncation or arithmetic.
REQ-021 X or Z on sel SHALL produce X on out in simulation.
REQ-022 An assertion SHALL flag sel=3 when the assertion is enabled, with no effect on RTL behaviour.

Reset
REQ-023 While reset=1 at a rising clk edge, out_q SHALL become 0 and err_sticky SHALL become 0.
REQ-024 reset SHALL NOT affect the combinational outputs out and sel_err.
REQ-025 Reset has priority over sel=3 at the same edge, so err_sticky is 0 after that edge.
REQ-026 Deasserting reset mid-operation SHALL make out_q load out at the next edge.
REQ-027 Before the first reset, out_q and err_sticky are unspecified.

Structure
REQ-028 A shared package mux_pkg SHALL hold the default width constant (5) and the select encodings SEL_IN0=0, SEL_IN1=1, SEL_IN2=2 and SEL_BAD=3.
REQ-029 One sub-module, mux_4_3_sel, SHALL be the purely combinational select.
REQ-030 mux_4_3_sel SHALL be implemented as a case statement with a default branch, driving out and sel_err.
REQ-031 The top level SHALL add only the out_q and err_sticky registers.
REQ-032 No other hierarchy is allowed.

Verification
REQ-033 All zero, sel=0, then in0=5 -> out=5 immediately; out_q=5 after the next clk edge.
REQ-034 in0=5, in1=0, sel changes 0->1 -> out changes 5->0 in the same step; sel_err=0.
REQ-035 in0=1, in1=2, in2=31, sel=2 -> out=31; out_q=31 one cycle later.
REQ-036 sel=3 with in0=in1=in2=31 -> out=0 and sel_err=1.
REQ-037 After the REQ-036 edge, err_sticky=1; it stays 1 after sel returns to 0.
REQ-038 reset=1 for one edge with sel=3 and in2=7 -> out_q=0 and err_sticky=0 after the edge; out follows sel throughout.

Source files
------------

// File: rtl/mux_pkg.sv
// +----------------------------------------------------------------------+
// | mux_pkg: shared width default and select encodings for mux_4_3        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  localparam int unsigned W_DEFAULT = 5;

  localparam logic [1:0] SEL_IN0 = 2'd0;
  localparam logic [1:0] SEL_IN1 = 2'd1;
  localparam logic [1:0] SEL_IN2 = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mux_4_3_sel.sv
// +----------------------------------------------------------------------+
// | mux_4_3_sel: purely combinational 3-of-4 select with illegal-code flag|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_4_3_sel
  import mux_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [1:0]   sel,
  output logic [W-1:0] out,
  output logic         sel_err
);

  always_comb begin
    out     = '0;
    sel_err = 1'b0;
    case (sel)
      SEL_IN0: out = in0;
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      SEL_BAD: sel_err = 1'b1;
      // Only reachable with an unknown select; propagate the unknown.
      default: begin
        out     = 'x;
        sel_err = 1'bx;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux_4_3.sv
// +----------------------------------------------------------------------+
// | mux_4_3: 3-input mux with registered copy and sticky select error     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mux_4_3
  import mux_pkg::*;
#(
  parameter int unsigned W          = W_DEFAULT,
  parameter bit          SEL_CHK_EN = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [1:0]   sel,
  output logic [W-1:0] out,
  output logic [W-1:0] out_q,
  output logic         sel_err,
  output logic         err_sticky
);

  logic [W-1:0] out_q_q;
  logic [W-1:0] out_q_d;
  logic         err_sticky_q;
  logic         err_sticky_d;

  mux_4_3_sel #(
    .W (W)
  ) u_sel (
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .sel     (sel),
    .out     (out),
    .sel_err (sel_err)
  );

  always_comb begin
    out_q_d      = out;
    err_sticky_d = err_sticky_q | sel_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q_q      <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_q_q      <= out_q_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_q      = out_q_q;
  assign err_sticky = err_sticky_q;

  // Optional runtime check for the illegal select code; no effect on logic.
  generate
    if (SEL_CHK_EN) begin : g_sel_chk
      a_sel_legal : assert property (@(posedge clk) disable iff (reset) sel != SEL_BAD)
        else $error("mux_4_3: illegal select code sampled");
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mux_4_3.sv
// +----------------------------------------------------------------------+
// | tb_mux_4_3: directed self-checking bench for mux_4_3                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mux_4_3;

  logic       clk;
  logic       reset;
  logic [4:0] in0;
  logic [4:0] in1;
  logic [4:0] in2;
  logic [1:0] sel;
  logic [4:0] out;
  logic [4:0] out_q;
  logic       sel_err;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  mux_4_3 #(
    .W (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .sel        (sel),
    .out        (out),
    .out_q      (out_q),
    .sel_err    (sel_err),
    .err_sticky (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in0 = '0; in1 = '0; in2 = '0; sel = 2'd0;
    tick();
    checks++;
    if (out_q !== 5'd0) begin
      errors++; $display("FAIL reset_out_q: got %0d expected 0", out_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++; $display("FAIL reset_err_sticky: got %0b expected 0", err_sticky);
    end
    reset = 1'b0;
  endtask

  task automatic test_sel0();
    in0 = 5'd5; sel = 2'd0;
    #1;
    checks++;
    if (out !== 5'd5) begin
      errors++; $display("FAIL sel0_out: got %0d expected 5", out);
    end
    tick();
    checks++;
    if (out_q !== 5'd5) begin
      errors++; $display("FAIL sel0_out_q: got %0d expected 5", out_q);
    end
  endtask

  task automatic test_sel_switch();
    in0 = 5'd5; in1 = 5'd0; sel = 2'd1;
    #1;
    checks++;
    if (out !== 5'd0) begin
      errors++; $display("FAIL sel1_out: got %0d expected 0", out);
    end
    checks++;
    if (sel_err !== 1'b0) begin
      errors++; $display("FAIL sel1_sel_err: got %0b expected 0", sel_err);
    end
  endtask

  task automatic test_sel2();
    in0 = 5'd1; in1 = 5'd2; in2 = 5'd31; sel = 2'd2;
    #1;
    checks++;
    if (out !== 5'd31) begin
      errors++; $display("FAIL sel2_out: got %0d expected 31", out);
    end
    tick();
    checks++;
    if (out_q !== 5'd31) begin
      errors++; $display("FAIL sel2_out_q: got %0d expected 31", out_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++; $display("FAIL sel2_err_sticky: got %0b expected 0", err_sticky);
    end
  endtask

  task automatic test_bad_sel();
    in0 = 5'd31; in1 = 5'd31; in2 = 5'd31; sel = 2'd3;
    #1;
    checks++;
    if (out !== 5'd0) begin
      errors++; $display("FAIL bad_out: got %0d expected 0", out);
    end
    checks++;
    if (sel_err !== 1'b1) begin
      errors++; $display("FAIL bad_sel_err: got %0b expected 1", sel_err);
    end
    tick();
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++; $display("FAIL bad_err_sticky: got %0b expected 1", err_sticky);
    end
    checks++;
    if (out_q !== 5'd0) begin
      errors++; $display("FAIL bad_out_q: got %0d expected 0", out_q);
    end
  endtask

  task automatic test_sticky_hold();
    sel = 2'd0;
    #1;
    checks++;
    if (sel_err !== 1'b0) begin
      errors++; $display("FAIL hold_sel_err: got %0b expected 0", sel_err);
    end
    tick();
    tick();
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++; $display("FAIL hold_err_sticky: got %0b expected 1", err_sticky);
    end
    checks++;
    if (out_q !== 5'd31) begin
      errors++; $display("FAIL hold_out_q: got %0d expected 31", out_q);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; sel = 2'd3; in2 = 5'd7;
    #1;
    checks++;
    if (out !== 5'd0 || sel_err !== 1'b1) begin
      errors++; $display("FAIL rstpri_comb: got out=%0d err=%0b expected out=0 err=1", out, sel_err);
    end
    tick();
    checks++;
    if (out_q !== 5'd0) begin
      errors++; $display("FAIL rstpri_out_q: got %0d expected 0", out_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++; $display("FAIL rstpri_err_sticky: got %0b expected 0", err_sticky);
    end
    sel = 2'd2;
    #1;
    checks++;
    if (out !== 5'd7) begin
      errors++; $display("FAIL rstpri_out_follow: got %0d expected 7", out);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (out_q !== 5'd7 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL rst_release: got out_q=%0d sticky=%0b expected out_q=7 sticky=0", out_q, err_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sv [4];
    logic [4:0] ev [4];
    sv = '{2'd0, 2'd1, 2'd2, 2'd0};
    ev = '{5'd10, 5'd21, 5'd12, 5'd10};
    in0 = 5'd10; in1 = 5'd21; in2 = 5'd12;
    for (int i = 0; i < 4; i++) begin
      sel = sv[i];
      #1;
      checks++;
      if (out !== ev[i]) begin
        errors++; $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, out, ev[i]);
      end
      tick();
      checks++;
      if (out_q !== ev[i]) begin
        errors++; $display("FAIL b2b_out_q[%0d]: got %0d expected %0d", i, out_q, ev[i]);
      end
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++; $display("FAIL b2b_err_sticky: got %0b expected 0", err_sticky);
    end
  endtask

  initial begin
    reset = 1'b0; in0 = '0; in1 = '0; in2 = '0; sel = 2'd0;
    @(negedge clk);
    test_reset();
    test_sel0();
    test_sel_switch();
    test_sel2();
    test_bad_sel();
    test_sticky_hold();
    test_reset_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
